lock_code_tx: RTL and testbench
===============================

Name: lock_code_tx

Overview:
- Serial code transmitter: the driving end of the lock/unlock sequence-detector interface.
- Shifts a CODE_LEN-bit code onto `seq`, MSB first, holding each bit for BIT_CYCLES clocks.
- Then watches the detector's `det`/`error` responses and reports pass/fail/timeout to the host.
- Sits between the host controller and the lock detector, on the same clock.

Parameters:
- CODE_LEN, 4, number of code bits sent per transaction (≥2).
- BIT_CYCLES, 2, clocks each bit is held on `seq` (≥1).
- RESP_TIMEOUT, 8, clocks to wait for a detector response after the last bit (≥1).
- DEFAULT_CODE, 4'b1011, code used when `use_default`=1 (width CODE_LEN).

Ports:
- clock, input, 1, single system clock, rising edge.
- resetphase, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to send; accepted only in IDLE.
- use_default, input, 1, sampled with `start`: 1 selects DEFAULT_CODE, 0 selects `code`.
- code, input, CODE_LEN, host code, sampled when `start` is accepted.
- det, input, 1, detector "sequence detected" pulse/level.
- error, input, 1, detector error flag.
- seq, output, 1, serial bit to the detector.
- busy, output, 1, high from the cycle after acceptance until return to IDLE.
- done, output, 1, one-cycle pulse when the result is valid.
- pass, output, 1, valid with `done`: `det` seen and `error` not seen.
- timeout, output, 1, valid with `done`: no `det`/`error` within RESP_TIMEOUT.

Behaviour:
- Reset (`resetphase`=0, async): state=IDLE; seq=0, busy=0, done=0, pass=0, timeout=0; shift register, bit counter, cycle counter and timer all 0.
- Register update: all state changes on rising `clock`. Outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - seq=0.
  - `start`=1: latch the selected code into the shift register, set busy=1 next cycle, go to SEND.
  - `start` in any other state is ignored (no queueing).
- SEND:
  - seq = shift register MSB.
  - Cycle counter counts 0..BIT_CYCLES-1. At terminal count: shift left, bit counter++.
  - After bit CODE_LEN-1 completes, go to WAIT. Total SEND time = CODE_LEN*BIT_CYCLES clocks.
  - The first bit appears on `seq` the cycle after `start`.
- WAIT:
  - seq=0; timer counts up from 0.
  - `error`=1 (checked first) → pass=0, timeout=0, go DONE.
  - Else `det`=1 → pass=1, go DONE.
  - Else timer reaching RESP_TIMEOUT-1 → timeout=1, pass=0, go DONE.
  - `det`/`error` asserted during SEND are also latched into sticky flags that are evaluated on the first WAIT cycle.
  - Simultaneous `det` and `error`: error wins, pass=0.
- DONE: done=1 for exactly one cycle; pass/timeout hold until the next accepted `start`. Next state IDLE, busy=0.
- Back-to-back: `start` in the cycle after DONE is accepted normally.
- Reset mid-operation: immediate abort to the reset values; no `done` pulse.
- Counter widths: $clog2 of the respective maximum, minimum 1 bit; no wrap beyond terminal count.

Optional Feature:
- Macro: LOCK_TX_PREAMBLE_EN.
- Defined:
  - A PREAMBLE state is inserted between acceptance and SEND.
  - It drives seq=0 for PRE_LEN*BIT_CYCLES clocks (PRE_LEN=2, package constant) to flush the detector's history.
  - Sticky `det`/`error` flags are cleared at PREAMBLE exit.
- Undefined: no PREAMBLE state; behaviour exactly as above.

Decomposition:
- Package `lock_pkg`:
  - state enum (IDLE, PREAMBLE, SEND, WAIT, DONE);
  - PRE_LEN constant;
  - default code constant;
  - shared by this block and the lock detector.
- One sub-module, `bit_timer`: a BIT_CYCLES-terminal counter with an enable and a terminal-count pulse, reused for bit pacing and the preamble.

Test Plan:
- Reset held 50 ns then released → all outputs 0, busy=0, seq=0.
- start, use_default=1, BIT_CYCLES=2 → seq sequence 1,1,0,0,1,1,1,1 over 8 clocks; stub detector pulses `det` 2 clocks later → done=1 with pass=1, timeout=0; busy low the next cycle.
- start, code=4'b0110, stub detector silent → after 8 SEND clocks + 8 WAIT clocks: done=1, timeout=1, pass=0.
- `det` and `error` both asserted on the same WAIT cycle → done=1, pass=0, timeout=0.
- Reset driven low on the third SEND bit → seq=0, busy=0 immediately; no `done` pulse; a subsequent start sends the full code from bit 3.
- LOCK_TX_PREAMBLE_EN defined → 4 zero clocks on `seq` precede the code; a `det` pulse during the preamble does not yield pass.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the lock/unlock sequence interface: state encoding,
// preamble length, default code and a counter-width helper.
package lock_pkg;

    typedef enum logic [2:0] {
        LOCK_IDLE     = 3'd0,
        LOCK_PREAMBLE = 3'd1,
        LOCK_SEND     = 3'd2,
        LOCK_WAIT     = 3'd3,
        LOCK_DONE     = 3'd4
    } lock_state_e;

    // Number of zero bit-slots sent ahead of the code to flush detector history.
    localparam int unsigned PRE_LEN = 2;

    localparam logic [3:0] LOCK_DEFAULT_CODE = 4'b1011;

    // Width needed to count 0..max_count-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-slot pacing counter: counts 0..BIT_CYCLES-1 while enabled and flags the
// last cycle of each slot with tc.
module bit_timer
    import lock_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int unsigned CW = cnt_width(BIT_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count and terminal-count flag; wraps to zero at the end of a slot.
    always_comb begin
        cnt_d = cnt_q;
        tc    = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == TERM) begin
                tc    = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lock_code_tx.sv
// Serial code transmitter driving the lock sequence detector: shifts a code
// out MSB first, then waits for the detector's det/error response.
// Optional: define LOCK_TX_PREAMBLE_EN to send PRE_LEN zero bit-slots first.
module lock_code_tx
    import lock_pkg::*;
#(
    parameter int unsigned         CODE_LEN     = 4,
    parameter int unsigned         BIT_CYCLES   = 2,
    parameter int unsigned         RESP_TIMEOUT = 8,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE = LOCK_DEFAULT_CODE
) (
    input  logic                clock,
    input  logic                resetphase,
    input  logic                start,
    input  logic                use_default,
    input  logic [CODE_LEN-1:0] code,
    input  logic                det,
    input  logic                error,
    output logic                seq,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timeout
);

    localparam logic [2:0] S_IDLE     = LOCK_IDLE;
    localparam logic [2:0] S_PREAMBLE = LOCK_PREAMBLE;
    localparam logic [2:0] S_SEND     = LOCK_SEND;
    localparam logic [2:0] S_WAIT     = LOCK_WAIT;
    localparam logic [2:0] S_DONE     = LOCK_DONE;

    // The bit counter also paces the preamble, so size it for the larger use.
    localparam int unsigned BW  = cnt_width(CODE_LEN);
    localparam int unsigned PW  = cnt_width(PRE_LEN);
    localparam int unsigned BCW = (BW > PW) ? BW : PW;
    localparam int unsigned TW  = cnt_width(RESP_TIMEOUT);

    localparam logic [BCW-1:0] LAST_BIT   = BCW'(CODE_LEN - 1);
    localparam logic [BCW-1:0] LAST_PRE   = BCW'(PRE_LEN - 1);
    localparam logic [TW-1:0]  TIMER_TERM = TW'(RESP_TIMEOUT - 1);

    logic [2:0]          state_q,      state_d;
    logic [CODE_LEN-1:0] shreg_q,      shreg_d;
    logic [BCW-1:0]      bit_cnt_q,    bit_cnt_d;
    logic [TW-1:0]       timer_q,      timer_d;
    logic                sticky_det_q, sticky_det_d;
    logic                sticky_err_q, sticky_err_d;
    logic                seq_q,        seq_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;
    logic                pass_q,       pass_d;
    logic                timeout_q,    timeout_d;

    logic slot_en;
    logic slot_clr;
    logic slot_tc;
    logic resp_det;
    logic resp_err;

    assign slot_en  = (state_q == S_SEND) || (state_q == S_PREAMBLE);
    assign slot_clr = (state_q == S_IDLE);

    bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk   (clock),
        .rst_n (resetphase),
        .en    (slot_en),
        .clr   (slot_clr),
        .tc    (slot_tc)
    );

    // Responses seen during SEND count as if they arrived on the first WAIT cycle.
    assign resp_det = det   | sticky_det_q;
    assign resp_err = error | sticky_err_q;

    // Transaction sequencing and result capture.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        timer_d      = timer_q;
        sticky_det_d = sticky_det_q;
        sticky_err_d = sticky_err_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d      = use_default ? DEFAULT_CODE : code;
                    bit_cnt_d    = '0;
                    timer_d      = '0;
                    sticky_det_d = 1'b0;
                    sticky_err_d = 1'b0;
                    pass_d       = 1'b0;
                    timeout_d    = 1'b0;
`ifdef LOCK_TX_PREAMBLE_EN
                    state_d      = S_PREAMBLE;
`else
                    state_d      = S_SEND;
`endif
                end
            end

            S_PREAMBLE: begin
                if (slot_tc) begin
                    if (bit_cnt_q == LAST_PRE) begin
                        bit_cnt_d    = '0;
                        sticky_det_d = 1'b0;
                        sticky_err_d = 1'b0;
                        state_d      = S_SEND;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            S_SEND: begin
                sticky_det_d = sticky_det_q | det;
                sticky_err_d = sticky_err_q | error;
                if (slot_tc) begin
                    shreg_d = {shreg_q[CODE_LEN-2:0], 1'b0};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        timer_d   = '0;
                        state_d   = S_WAIT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (resp_err) begin
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = S_DONE;
                end else if (resp_det) begin
                    pass_d    = 1'b1;
                    timeout_d = 1'b0;
                    state_d   = S_DONE;
                end else if (timer_q == TIMER_TERM) begin
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_DONE: begin
                sticky_det_d = 1'b0;
                sticky_err_d = 1'b0;
                timer_d      = '0;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet line
    // up with the state they describe.
    always_comb begin
        seq_d  = (state_d == S_SEND) & shreg_d[CODE_LEN-1];
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge resetphase) begin
        if (!resetphase) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            timer_q      <= '0;
            sticky_det_q <= 1'b0;
            sticky_err_q <= 1'b0;
            seq_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            timer_q      <= timer_d;
            sticky_det_q <= sticky_det_d;
            sticky_err_q <= sticky_err_d;
            seq_q        <= seq_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
        end
    end

    assign seq     = seq_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_lock_code_tx.sv
// Self-checking bench for lock_code_tx: directed and randomized transactions
// against a cycle-indexed reference model. Honours LOCK_TX_PREAMBLE_EN.
module tb_lock_code_tx;
    import lock_pkg::*;

    localparam int unsigned CL  = 4;
    localparam int unsigned BC  = 2;
    localparam int unsigned RT  = 8;
    localparam logic [CL-1:0] DEF = 4'b1011;
`ifdef LOCK_TX_PREAMBLE_EN
    localparam int PRE = PRE_LEN * BC;
`else
    localparam int PRE = 0;
`endif
    localparam int SEND_END = PRE + CL * BC;

    logic          clock = 1'b0;
    logic          resetphase;
    logic          start;
    logic          use_default;
    logic [CL-1:0] code;
    logic          det;
    logic          error;
    logic          seq, busy, done, pass, timeout;

    int n_checks = 0;
    int n_pass   = 0;

    bit det_a [0:63];
    bit err_a [0:63];

    lock_code_tx #(
        .CODE_LEN     (CL),
        .BIT_CYCLES   (BC),
        .RESP_TIMEOUT (RT),
        .DEFAULT_CODE (DEF)
    ) dut (
        .clock       (clock),
        .resetphase  (resetphase),
        .start       (start),
        .use_default (use_default),
        .code        (code),
        .det         (det),
        .error       (error),
        .seq         (seq),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic clear_resp();
        for (int i = 0; i < 64; i++) begin
            det_a[i] = 1'b0;
            err_a[i] = 1'b0;
        end
    endtask

    // Interval i (i>=1) is the i-th clock period after the edge that accepts
    // start; det_a/err_a[i] are driven during interval i.
    task automatic run_txn(input logic [CL-1:0] c, input bit ud, input bit noisy);
        logic [CL-1:0] eff;
        bit st_det, st_err, e_pass, e_to, hit_d, hit_e;
        int w, dn, idx;
        logic exp_seq;

        eff = ud ? DEF : c;
        st_det = 1'b0;
        st_err = 1'b0;
        for (int i = PRE + 1; i <= SEND_END; i++) begin
            st_det |= det_a[i];
            st_err |= err_a[i];
        end
        e_pass = 1'b0;
        e_to   = 1'b0;
        w = 0;
        forever begin
            hit_e = err_a[SEND_END + 1 + w] | ((w == 0) & st_err);
            hit_d = det_a[SEND_END + 1 + w] | ((w == 0) & st_det);
            if (hit_e) break;
            if (hit_d) begin e_pass = 1'b1; break; end
            if (w == int'(RT) - 1) begin e_to = 1'b1; break; end
            w++;
        end
        dn = SEND_END + w + 2;

        @(negedge clock);
        start = 1'b1; code = c; use_default = ud; det = 1'b0; error = 1'b0;
        @(posedge clock);
        #1;
        start = 1'b0; code = CL'($urandom); use_default = 1'($urandom);
        det = det_a[1]; error = err_a[1];

        for (int i = 1; i <= dn + 1; i++) begin
            @(negedge clock);
            if (i > PRE && i <= SEND_END) begin
                idx = int'(CL) - 1 - (i - PRE - 1) / int'(BC);
                exp_seq = eff[idx];
            end else begin
                exp_seq = 1'b0;
            end
            check("seq", 32'(seq), 32'(exp_seq));
            check("busy", 32'(busy), 32'(i <= dn));
            check("done", 32'(done), 32'(i == dn));
            if (i >= dn) begin
                check("pass", 32'(pass), 32'(e_pass));
                check("timeout", 32'(timeout), 32'(e_to));
            end else begin
                check("pass_busy", 32'(pass), 32'd0);
                check("timeout_busy", 32'(timeout), 32'd0);
            end
            @(posedge clock);
            #1;
            // A start anywhere before returning to IDLE must be ignored.
            start = (noisy && (i + 1 <= dn)) ? 1'($urandom) : 1'b0;
            code = CL'($urandom);
            det = det_a[i + 1];
            error = err_a[i + 1];
        end
        start = 1'b0; det = 1'b0; error = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        resetphase = 1'b0;
        start = 1'b0; use_default = 1'b0; code = '0; det = 1'b0; error = 1'b0;
        clear_resp();
        #50;
        check("rst_seq", 32'(seq), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        @(negedge clock);
        resetphase = 1'b1;

        // Default code, detector answers two clocks after the last bit.
        clear_resp();
        det_a[SEND_END + 2] = 1'b1;
        run_txn(4'b0000, 1'b1, 1'b0);

        // Silent detector gives a timeout.
        clear_resp();
        run_txn(4'b0110, 1'b0, 1'b0);

        // det and error together: error wins.
        clear_resp();
        det_a[SEND_END + 3] = 1'b1;
        err_a[SEND_END + 3] = 1'b1;
        run_txn(4'b1001, 1'b0, 1'b0);

        // det early in the transfer (preamble slot when enabled).
        clear_resp();
        det_a[1] = 1'b1;
        run_txn(4'b0101, 1'b0, 1'b0);

        // Reset asserted during the third bit aborts the transfer.
        clear_resp();
        @(negedge clock);
        start = 1'b1; code = 4'b1110; use_default = 1'b0;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int i = 1; i < PRE + 2 * int'(BC) + 1; i++) @(posedge clock);
        #1;
        check("abort_pre_seq", 32'(seq), 32'd1);
        resetphase = 1'b0;
        #1;
        check("abort_seq", 32'(seq), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_timeout", 32'(timeout), 32'd0);
        repeat (3) begin
            @(negedge clock);
            check("abort_hold_done", 32'(done), 32'd0);
            check("abort_hold_busy", 32'(busy), 32'd0);
        end
        resetphase = 1'b1;
        run_txn(4'b1110, 1'b0, 1'b0);

        // Randomized transactions with sparse detector activity and stray starts.
        for (int t = 0; t < 40; t++) begin
            clear_resp();
            if ($urandom_range(0, 3) != 0) begin
                for (int i = 1; i <= SEND_END + int'(RT); i++) begin
                    det_a[i] = ($urandom_range(0, 11) == 0);
                    err_a[i] = ($urandom_range(0, 15) == 0);
                end
            end
            run_txn(CL'($urandom), 1'($urandom), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
